tube_scan_capture: RTL and testbench

- Passive reader of the multiplexed 8-digit seven-segment bus (sel, tub1, tub2) driven by the tube scan controller.
- Samples the scanned bus, decodes each digit's segment pattern back into the team's 6-bit character code, and reassembles the 48-bit display frame.
- Flags a complete frame with a one-cycle pulse.
- Used for on-board self-test and for bench checking of every display mode (PLAY, STUDY, song-name).

---
 rtl/tube_pkg.sv | 56 +++++
 rtl/tube_scan_capture_seg_to_char.sv | 41 ++++
 rtl/tube_scan_capture.sv | 167 ++++++++++++++++
 tb/tb_tube_scan_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared character codes and seven-segment glyphs ({a,b,c,d,e,f,g}, active-high) for the tube driver and capture logic.
// Blank decodes to code 0, which is also CHAR_A; S omits g so that it stays distinct from 5.
package tube_pkg;

    localparam logic [5:0] CHAR_A     = 6'b000000;
    localparam logic [5:0] CHAR_D     = 6'b000011;
    localparam logic [5:0] CHAR_L     = 6'b001011;
    localparam logic [5:0] CHAR_P     = 6'b001111;
    localparam logic [5:0] CHAR_S     = 6'b010010;
    localparam logic [5:0] CHAR_T     = 6'b010011;
    localparam logic [5:0] CHAR_U     = 6'b101100;
    localparam logic [5:0] CHAR_Y     = 6'b110000;
    localparam logic [5:0] CHAR_1     = 6'b110011;
    localparam logic [5:0] CHAR_2     = 6'b110100;
    localparam logic [5:0] CHAR_3     = 6'b110101;
    localparam logic [5:0] CHAR_4     = 6'b110110;
    localparam logic [5:0] CHAR_5     = 6'b110111;
    localparam logic [5:0] CHAR_6     = 6'b111000;
    localparam logic [5:0] CHAR_7     = 6'b111001;
    localparam logic [5:0] CHAR_NAT   = 6'b111100;
    localparam logic [5:0] CHAR_HI    = 6'b111101;
    localparam logic [5:0] CHAR_LO    = 6'b111110;
    localparam logic [5:0] CHAR_UNK   = 6'b111111;
    localparam logic [5:0] CHAR_BLANK = 6'b000000;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_L     = 7'b0001110;
    localparam logic [6:0] SEG_P     = 7'b1100111;
    localparam logic [6:0] SEG_S     = 7'b1011010;
    localparam logic [6:0] SEG_T     = 7'b0001111;
    localparam logic [6:0] SEG_U     = 7'b0111110;
    localparam logic [6:0] SEG_Y     = 7'b0111011;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_NAT   = 7'b0110111;
    localparam logic [6:0] SEG_HI    = 7'b1000000;
    localparam logic [6:0] SEG_LO    = 7'b0001000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LOST    = 2'd2
    } state_e;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/tube_scan_capture_seg_to_char.sv
// Combinational glyph decoder: 7-bit segment pattern to 6-bit character code plus a match flag.
// Zero latency; no flow control.
module seg_to_char
    import tube_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [5:0] code_o,
    output logic       vld_o
);

    always_comb begin
        code_o = CHAR_UNK;
        vld_o  = 1'b1;
        case (seg_i)
            SEG_BLANK: code_o = CHAR_BLANK;
            SEG_A:     code_o = CHAR_A;
            SEG_D:     code_o = CHAR_D;
            SEG_L:     code_o = CHAR_L;
            SEG_P:     code_o = CHAR_P;
            SEG_S:     code_o = CHAR_S;
            SEG_T:     code_o = CHAR_T;
            SEG_U:     code_o = CHAR_U;
            SEG_Y:     code_o = CHAR_Y;
            SEG_1:     code_o = CHAR_1;
            SEG_2:     code_o = CHAR_2;
            SEG_3:     code_o = CHAR_3;
            SEG_4:     code_o = CHAR_4;
            SEG_5:     code_o = CHAR_5;
            SEG_6:     code_o = CHAR_6;
            SEG_7:     code_o = CHAR_7;
            SEG_NAT:   code_o = CHAR_NAT;
            SEG_HI:    code_o = CHAR_HI;
            SEG_LO:    code_o = CHAR_LO;
            default: begin
                code_o = CHAR_UNK;
                vld_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/tube_scan_capture.sv
// Passive capture of the scanned 8-digit tube bus into a 48-bit frame; frame_valid lands STABLE_CYC+2 cycles
// after the last digit settles at the pins. Purely observing: no backpressure, the bus is never stalled.
module tube_scan_capture
    import tube_pkg::*;
#(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 200000,
    parameter int CNT_W       = 18
) (
    input  logic        sys_clk,
    input  logic        sys_rest,
    input  logic [7:0]  sel,
    input  logic [7:0]  tub1,
    input  logic [7:0]  tub2,
    output logic [47:0] frame,
    output logic [7:0]  dp_mask,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        decode_err,
    output logic        scan_lost
);

    localparam int SW = $clog2(STABLE_CYC + 1);

    logic [7:0]       sel_q, tub1_q, tub2_q, last_sel_q, last_seg_q;
    logic [SW-1:0]    stab_q, stab_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    state_e           state_q, state_d;
    logic [7:0]       seen_q, seen_d;
    logic [47:0]      shadow_q, shadow_d, frame_q, frame_d;
    logic [7:0]       shdp_q, shdp_d, dp_q, dp_d;
    logic             fv_q, fv_d, fc_q, fc_d, err_q, err_d, lost_q, lost_d;

    logic [7:0] seg_byte;
    logic       bus_changed, accept;
    logic [5:0] dec_code, digit_code;
    logic       dec_vld;

    assign seg_byte    = (|sel_q[7:4]) ? tub1_q : tub2_q;
    assign bus_changed = (sel_q != last_sel_q) || (seg_byte != last_seg_q);

    always_comb begin
        stab_d = stab_q;
        if (bus_changed)
            stab_d = SW'(1);
        else if (stab_q != SW'(STABLE_CYC))
            stab_d = stab_q + SW'(1);
    end

    // Accept only on the transition into the saturated count, so a long dwell captures once.
    assign accept = (stab_d == SW'(STABLE_CYC)) && (bus_changed || (stab_q != SW'(STABLE_CYC)))
                    && is_onehot8(sel_q);

    seg_to_char u_seg_to_char (
        .seg_i  (seg_byte[7:1]),
        .code_o (dec_code),
        .vld_o  (dec_vld)
    );

    assign digit_code = dec_vld ? dec_code : CHAR_UNK;

    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        shadow_d = shadow_q;
        shdp_d   = shdp_q;
        frame_d  = frame_q;
        dp_d     = dp_q;
        fv_d     = 1'b0;
        fc_d     = 1'b0;
        lost_d   = lost_q;
        err_d    = err_q | (accept & ~dec_vld);
        tmo_d    = tmo_q;

        if (state_q == IDLE || accept)
            tmo_d = '0;
        else if (tmo_q != CNT_W'(TIMEOUT_CYC))
            tmo_d = tmo_q + CNT_W'(1);

        if (state_q == COLLECT && seen_q == 8'hFF) begin
            frame_d = shadow_q;
            dp_d    = shdp_q;
            fv_d    = 1'b1;
            fc_d    = ({shadow_q, shdp_q} != {frame_q, dp_q});
            seen_d  = 8'h00;
        end

        if (accept) begin
            for (int j = 0; j < 8; j++) begin
                if (sel_q[j]) begin
                    shadow_d[j*6 +: 6] = digit_code;
                    shdp_d[j]          = seg_byte[0];
                end
            end
            seen_d = seen_d | sel_q;
        end

        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = COLLECT;
            end
            COLLECT: begin
                if (!accept && tmo_q == CNT_W'(TIMEOUT_CYC)) begin
                    state_d = LOST;
                    lost_d  = 1'b1;
                    seen_d  = 8'h00;
                end
            end
            LOST: begin
                if (accept) begin
                    state_d = COLLECT;
                    lost_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rest) begin
            sel_q      <= '0;
            tub1_q     <= '0;
            tub2_q     <= '0;
            last_sel_q <= '0;
            last_seg_q <= '0;
            stab_q     <= '0;
            tmo_q      <= '0;
            state_q    <= IDLE;
            seen_q     <= '0;
            shadow_q   <= '0;
            shdp_q     <= '0;
            frame_q    <= '0;
            dp_q       <= '0;
            fv_q       <= 1'b0;
            fc_q       <= 1'b0;
            err_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            sel_q      <= sel;
            tub1_q     <= tub1;
            tub2_q     <= tub2;
            last_sel_q <= sel_q;
            last_seg_q <= seg_byte;
            stab_q     <= stab_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            seen_q     <= seen_d;
            shadow_q   <= shadow_d;
            shdp_q     <= shdp_d;
            frame_q    <= frame_d;
            dp_q       <= dp_d;
            fv_q       <= fv_d;
            fc_q       <= fc_d;
            err_q      <= err_d;
            lost_q     <= lost_d;
        end
    end

    assign frame         = frame_q;
    assign dp_mask       = dp_q;
    assign frame_valid   = fv_q;
    assign frame_changed = fc_q;
    assign decode_err    = err_q;
    assign scan_lost     = lost_q;

endmodule

// File: tb/tb_tube_scan_capture.sv
// Bench for tube_scan_capture: scans frames onto the bus, queues the expected frame per full scan
// and checks each frame_valid pulse against the queue head.
module tb_tube_scan_capture;

    localparam int STABLE = 4;
    localparam int TMO    = 300;
    localparam int CW     = 9;
    localparam int DWELL  = 8;
    localparam int NVEC   = 19;

    logic        sys_clk = 1'b0;
    logic        sys_rest;
    logic [7:0]  sel, tub1, tub2;
    logic [47:0] frame;
    logic [7:0]  dp_mask;
    logic        frame_valid, frame_changed, decode_err, scan_lost;

    always #5 sys_clk = ~sys_clk;

    tube_scan_capture #(
        .STABLE_CYC  (STABLE),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (CW)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rest      (sys_rest),
        .sel           (sel),
        .tub1          (tub1),
        .tub2          (tub2),
        .frame         (frame),
        .dp_mask       (dp_mask),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .decode_err    (decode_err),
        .scan_lost     (scan_lost)
    );

    typedef struct packed {
        logic [47:0] frame;
        logic [7:0]  dp;
        logic        changed;
    } exp_t;

    typedef struct {
        logic [6:0] seg;
        logic [5:0] code;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [55:0] prev_exp;
    int errors = 0, checks = 0, fv_cnt = 0, fc_cnt = 0, cyc = 0, last_cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (frame_valid) begin
            fv_cnt++;
            if (frame_changed) fc_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_valid: frame=%0h with empty scoreboard", frame);
            end else begin
                mon_e = sb_q.pop_front();
                check("frame", 64'(frame), 64'(mon_e.frame));
                check("dp_mask", 64'(dp_mask), 64'(mon_e.dp));
                check("frame_changed", 64'(frame_changed), 64'(mon_e.changed));
                check("latency", 64'(cyc - last_cyc), 64'(STABLE + 2));
            end
        end else if (frame_changed) begin
            checks++;
            errors++;
            $display("FAIL changed_without_valid: frame_changed=1 frame_valid=0");
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Digit k (0 = leftmost) takes pats[55-7k -: 7] and dp bit 7-k; glitch < 0 means no ghost select.
    task automatic scan(input logic [55:0] pats, input logic [7:0] dp, input int n_digits,
                        input int glitch, input logic [47:0] exp_frame);
        exp_t e;
        logic [7:0] seg;
        int j;
        if (n_digits == 8) begin
            e.frame   = exp_frame;
            e.dp      = dp;
            e.changed = ({exp_frame, dp} != prev_exp);
            prev_exp  = {exp_frame, dp};
            sb_q.push_back(e);
        end
        for (int k = 0; k < n_digits; k++) begin
            if (k == glitch) begin
                sel  = 8'b0111_0000;
                tub1 = 8'($urandom);
                tub2 = 8'($urandom);
                tick(2);
            end
            j   = 7 - k;
            seg = {pats[55-7*k -: 7], dp[j]};
            sel    = 8'h00;
            sel[j] = 1'b1;
            if (j >= 4) begin
                tub1 = seg;
                tub2 = 8'($urandom);
            end else begin
                tub1 = 8'($urandom);
                tub2 = seg;
            end
            if (k == 7) last_cyc = cyc;
            tick(DWELL);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) tick(1);
        check("drain", 64'(sb_q.size()), 64'd0);
        sel = 8'h00;
        tick(4);
    endtask

    task automatic do_reset();
        sys_rest = 1'b1;
        sel  = 8'h00;
        tub1 = 8'h00;
        tub2 = 8'h00;
        tick(1);
        sys_rest = 1'b0;
        prev_exp = '0;
    endtask

    localparam logic [55:0] PLAY_PAT = {7'b1100111, 7'b0001110, 7'b1110111, 7'b0111011,
                                        7'b0000000, 7'b0000000, 7'b0110111, 7'b0110000};
    localparam logic [47:0] PLAY_EXP = 48'h3CB0_3000_0F33;
    localparam logic [55:0] STUDY_PAT = {7'b1011010, 7'b0001111, 7'b0111110, 7'b0111101,
                                         7'b0111011, 7'b0000000, 7'b0000000, 7'b1111001};
    localparam logic [47:0] STUDY_EXP = {6'b010010, 6'b010011, 6'b101100, 6'b000011,
                                         6'b110000, 6'b000000, 6'b000000, 6'b110101};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[NVEC];
        logic [55:0] pats;
        logic [47:0] expf;
        int fv0, fc0;

        tbl[0]  = '{7'b0000000, 6'b000000};
        tbl[1]  = '{7'b1110111, 6'b000000};
        tbl[2]  = '{7'b0111101, 6'b000011};
        tbl[3]  = '{7'b0001110, 6'b001011};
        tbl[4]  = '{7'b1100111, 6'b001111};
        tbl[5]  = '{7'b1011010, 6'b010010};
        tbl[6]  = '{7'b0001111, 6'b010011};
        tbl[7]  = '{7'b0111110, 6'b101100};
        tbl[8]  = '{7'b0111011, 6'b110000};
        tbl[9]  = '{7'b0110000, 6'b110011};
        tbl[10] = '{7'b1101101, 6'b110100};
        tbl[11] = '{7'b1111001, 6'b110101};
        tbl[12] = '{7'b0110011, 6'b110110};
        tbl[13] = '{7'b1011011, 6'b110111};
        tbl[14] = '{7'b1011111, 6'b111000};
        tbl[15] = '{7'b1110000, 6'b111001};
        tbl[16] = '{7'b0110111, 6'b111100};
        tbl[17] = '{7'b1000000, 6'b111101};
        tbl[18] = '{7'b0001000, 6'b111110};

        sys_rest = 1'b1;
        sel  = 8'h00;
        tub1 = 8'h00;
        tub2 = 8'h00;
        prev_exp = '0;
        @(posedge sys_clk);
        #1;
        tick(2);
        sys_rest = 1'b0;

        check("rst_frame", 64'(frame), 64'd0);
        check("rst_dp_mask", 64'(dp_mask), 64'd0);
        check("rst_frame_valid", 64'(frame_valid), 64'd0);
        check("rst_frame_changed", 64'(frame_changed), 64'd0);
        check("rst_decode_err", 64'(decode_err), 64'd0);
        check("rst_scan_lost", 64'(scan_lost), 64'd0);

        // PLAY twice: two frames, only the first one flagged as changed
        fv0 = fv_cnt;
        fc0 = fc_cnt;
        scan(PLAY_PAT, 8'h00, 8, -1, PLAY_EXP);
        scan(PLAY_PAT, 8'h00, 8, -1, PLAY_EXP);
        drain();
        check("play_fv_count", 64'(fv_cnt - fv0), 64'd2);
        check("play_fc_count", 64'(fc_cnt - fc0), 64'd1);
        check("play_frame", 64'(frame), 64'h3CB0_3000_0F33);

        // Switch to STUDY: changed on the first STUDY frame only
        fc0 = fc_cnt;
        scan(PLAY_PAT, 8'h00, 8, -1, PLAY_EXP);
        scan(STUDY_PAT, 8'h04, 8, -1, STUDY_EXP);
        scan(STUDY_PAT, 8'h04, 8, -1, STUDY_EXP);
        drain();
        check("study_fc_count", 64'(fc_cnt - fc0), 64'd1);

        // Ghost select with three bits set mid-scan
        fv0 = fv_cnt;
        scan(PLAY_PAT, 8'h00, 8, 4, PLAY_EXP);
        drain();
        check("ghost_fv_count", 64'(fv_cnt - fv0), 64'd1);

        // Every glyph at every position, rotating through the table
        for (int i = 0; i < NVEC; i++) begin
            for (int k = 0; k < 8; k++) begin
                pats[55-7*k -: 7] = tbl[(i + k) % NVEC].seg;
                expf[47-6*k -: 6] = tbl[(i + k) % NVEC].code;
            end
            scan(pats, 8'($urandom_range(0, 255)), 8, -1, expf);
        end
        drain();
        check("table_no_decode_err", 64'(decode_err), 64'd0);

        // Unmapped glyph on digit 5 (all segments but a,b)
        pats = PLAY_PAT;
        pats[55-35 -: 7] = 7'b0011111;
        expf = PLAY_EXP;
        expf[17:12] = 6'b111111;
        scan(pats, 8'h00, 8, -1, expf);
        drain();
        check("unk_decode_err", 64'(decode_err), 64'd1);
        scan(PLAY_PAT, 8'h00, 8, -1, PLAY_EXP);
        drain();
        check("unk_decode_err_sticky", 64'(decode_err), 64'd1);

        // Scan stalls after three digits long enough to time out
        check("pre_lost_scan_lost", 64'(scan_lost), 64'd0);
        fv0 = fv_cnt;
        scan(STUDY_PAT, 8'h00, 3, -1, 48'h0);
        sel = 8'h00;
        tick(TMO + 5);
        check("lost_scan_lost", 64'(scan_lost), 64'd1);
        check("lost_no_frame", 64'(fv_cnt - fv0), 64'd0);
        check("lost_frame_held", 64'(frame), 64'(PLAY_EXP));
        scan(STUDY_PAT, 8'h10, 8, -1, STUDY_EXP);
        drain();
        check("resume_scan_lost", 64'(scan_lost), 64'd0);
        check("resume_fv_count", 64'(fv_cnt - fv0), 64'd1);

        // Reset with six digits collected
        scan(PLAY_PAT, 8'h00, 6, -1, 48'h0);
        do_reset();
        check("mid_rst_frame", 64'(frame), 64'd0);
        check("mid_rst_dp_mask", 64'(dp_mask), 64'd0);
        check("mid_rst_frame_valid", 64'(frame_valid), 64'd0);
        check("mid_rst_frame_changed", 64'(frame_changed), 64'd0);
        check("mid_rst_decode_err", 64'(decode_err), 64'd0);
        check("mid_rst_scan_lost", 64'(scan_lost), 64'd0);
        fv0 = fv_cnt;
        scan(PLAY_PAT, 8'h81, 8, -1, PLAY_EXP);
        drain();
        tick(20);
        check("post_rst_fv_count", 64'(fv_cnt - fv0), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
